// File: rtl/regfile_pkg.sv
// Shared command-word layout, opcodes and readback-source encoding for register_file.
package regfile_pkg;

  localparam int unsigned GUARD_MSB  = 31;
  localparam int unsigned GUARD_LSB  = 28;
  localparam int unsigned OPC_MSB    = 27;
  localparam int unsigned OPC_LSB    = 24;
  localparam int unsigned STROBE_BIT = 23;
  localparam int unsigned DATA_MSB   = 22;

  localparam logic [3:0] RESET    = 4'd0;
  localparam logic [3:0] EN_TX    = 4'd1;
  localparam logic [3:0] EN_RX    = 4'd2;
  localparam logic [3:0] PH_SEL   = 4'd3;
  localparam logic [3:0] RUN_MEM  = 4'd4;
  localparam logic [3:0] READ_MEM = 4'd5;
  localparam logic [3:0] ADDR_MEM = 4'd6;
  localparam logic [3:0] BER_SI   = 4'd7;
  localparam logic [3:0] BER_SQ   = 4'd8;
  localparam logic [3:0] BER_EI   = 4'd9;
  localparam logic [3:0] BER_EQ   = 4'd10;
  localparam logic [3:0] BER_HI   = 4'd11;
  localparam logic [3:0] MEM_STAT = 4'd12;
  localparam logic [3:0] ECHO     = 4'd13;

  typedef enum logic [1:0] {
    SRC_STAT = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_BER  = 2'd2
  } rb_src_e;

endpackage

// File: rtl/register_file_strobe_detect.sv
// Rising-edge detector on the GPO strobe bit; one-cycle cmd_valid per edge.
module gpo_strobe_detect (
  input  logic clk,
  input  logic i_rst,
  input  logic i_strobe,
  output logic o_cmd_valid
);

  logic strobe_d_q, strobe_d_d;

  always_comb strobe_d_d = i_strobe;

  always_ff @(posedge clk) begin
    if (i_rst) strobe_d_q <= 1'b0;
    else       strobe_d_q <= strobe_d_d;
  end

  assign o_cmd_valid = i_strobe & ~strobe_d_q;

endmodule

// File: rtl/register_file.sv
// GPIO command decoder / readback mux between the soft processor and the datapath.
// Optional: define REGFILE_ECHO_EN to enable opcode 13 (ECHO) for link testing.
module register_file
  import regfile_pkg::*;
#(
  parameter int unsigned NB_ADDR_MEM = 15
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic [31:0]            i_gpo,
  input  logic [31:0]            i_data_log_from_mem,
  input  logic                   i_mem_full,
  input  logic [63:0]            i_ber_samp_I,
  input  logic [63:0]            i_ber_samp_Q,
  input  logic [63:0]            i_ber_error_I,
  input  logic [63:0]            i_ber_error_Q,
  output logic [31:0]            o_gpi,
  output logic                   o_rst,
  output logic                   o_enbTx,
  output logic                   o_enbRx,
  output logic [1:0]             o_phase_sel,
  output logic                   o_run_log,
  output logic                   o_read_log,
  output logic [NB_ADDR_MEM-1:0] o_addr_log_to_mem
);

  logic                   cmd_valid;
  logic                   cmd;
  logic [3:0]             op;
  logic [DATA_MSB:0]      data;
  logic                   ber_load;
  logic [31:0]            ber_word;
  logic                   unused_data;

  logic [31:0]            gpi_q, gpi_d;
  logic                   rst_q, rst_d;
  logic                   enb_tx_q, enb_tx_d;
  logic                   enb_rx_q, enb_rx_d;
  logic [1:0]             phase_sel_q, phase_sel_d;
  logic                   run_log_q, run_log_d;
  logic                   read_log_q, read_log_d;
  logic [NB_ADDR_MEM-1:0] addr_q, addr_d;
  logic [63:0]            ber_snap_q, ber_snap_d;
  rb_src_e                src_q, src_d;

  gpo_strobe_detect u_strobe (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_strobe    (i_gpo[STROBE_BIT]),
    .o_cmd_valid (cmd_valid)
  );

  assign op          = i_gpo[OPC_MSB:OPC_LSB];
  assign data        = i_gpo[DATA_MSB:0];
  assign cmd         = cmd_valid && (i_gpo[GUARD_MSB:GUARD_LSB] == 4'd0);
  assign unused_data = ^data[DATA_MSB:NB_ADDR_MEM];

  always_comb begin
    rst_d       = rst_q;
    enb_tx_d    = enb_tx_q;
    enb_rx_d    = enb_rx_q;
    phase_sel_d = phase_sel_q;
    run_log_d   = 1'b0;
    read_log_d  = 1'b0;
    addr_d      = addr_q;
    ber_snap_d  = ber_snap_q;
    src_d       = src_q;
    ber_load    = 1'b0;
    ber_word    = '0;
    gpi_d       = gpi_q;

    if (cmd) begin
      case (op)
        RESET:    rst_d       = data[0];
        EN_TX:    enb_tx_d    = data[0];
        EN_RX:    enb_rx_d    = data[0];
        PH_SEL:   phase_sel_d = data[1:0];
        RUN_MEM:  run_log_d   = 1'b1;
        READ_MEM: read_log_d  = 1'b1;
        ADDR_MEM: begin
          addr_d = data[NB_ADDR_MEM-1:0];
          src_d  = SRC_MEM;
        end
        BER_SI, BER_SQ, BER_EI, BER_EQ: begin
          case (op)
            BER_SI:  ber_snap_d = i_ber_samp_I;
            BER_SQ:  ber_snap_d = i_ber_samp_Q;
            BER_EI:  ber_snap_d = i_ber_error_I;
            default: ber_snap_d = i_ber_error_Q;
          endcase
          src_d    = SRC_BER;
          ber_load = 1'b1;
          ber_word = ber_snap_d[31:0];
        end
        BER_HI: begin
          src_d    = SRC_BER;
          ber_load = 1'b1;
          ber_word = ber_snap_q[63:32];
        end
        MEM_STAT: src_d = SRC_STAT;
`ifdef REGFILE_ECHO_EN
        ECHO: begin
          src_d    = SRC_BER;
          ber_load = 1'b1;
          ber_word = {9'b0, data};
        end
`endif
        default: ;
      endcase
    end

    // Source is resolved after decode so a source change takes effect in the edge cycle.
    case (src_d)
      SRC_MEM:  gpi_d = i_data_log_from_mem;
      SRC_STAT: gpi_d = {31'b0, i_mem_full};
      default:  gpi_d = ber_load ? ber_word : gpi_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      gpi_q       <= '0;
      rst_q       <= 1'b0;
      enb_tx_q    <= 1'b0;
      enb_rx_q    <= 1'b0;
      phase_sel_q <= '0;
      run_log_q   <= 1'b0;
      read_log_q  <= 1'b0;
      addr_q      <= '0;
      ber_snap_q  <= '0;
      src_q       <= SRC_STAT;
    end else begin
      gpi_q       <= gpi_d;
      rst_q       <= rst_d;
      enb_tx_q    <= enb_tx_d;
      enb_rx_q    <= enb_rx_d;
      phase_sel_q <= phase_sel_d;
      run_log_q   <= run_log_d;
      read_log_q  <= read_log_d;
      addr_q      <= addr_d;
      ber_snap_q  <= ber_snap_d;
      src_q       <= src_d;
    end
  end

  assign o_gpi             = gpi_q;
  assign o_rst             = rst_q;
  assign o_enbTx           = enb_tx_q;
  assign o_enbRx           = enb_rx_q;
  assign o_phase_sel       = phase_sel_q;
  assign o_run_log         = run_log_q;
  assign o_read_log        = read_log_q;
  assign o_addr_log_to_mem = addr_q;

endmodule

// File: tb/tb_register_file.sv
// Randomized + directed bench for register_file against a command-level reference model.
module tb_register_file;

  localparam int unsigned NB_ADDR_MEM = 15;

  logic                   clk = 1'b0;
  logic                   i_rst;
  logic [31:0]            i_gpo;
  logic [31:0]            i_data_log_from_mem;
  logic                   i_mem_full;
  logic [63:0]            i_ber_samp_I, i_ber_samp_Q, i_ber_error_I, i_ber_error_Q;
  logic [31:0]            o_gpi;
  logic                   o_rst, o_enbTx, o_enbRx, o_run_log, o_read_log;
  logic [1:0]             o_phase_sel;
  logic [NB_ADDR_MEM-1:0] o_addr_log_to_mem;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  // reference model state
  logic [31:0]            m_gpi;
  logic                   m_rst, m_tx, m_rx, m_run, m_read, m_prev;
  logic [1:0]             m_ph;
  logic [NB_ADDR_MEM-1:0] m_addr;
  logic [63:0]            m_snap;
  string                  m_src;

  register_file #(.NB_ADDR_MEM(NB_ADDR_MEM)) dut (
    .clk                 (clk),
    .i_rst               (i_rst),
    .i_gpo               (i_gpo),
    .i_data_log_from_mem (i_data_log_from_mem),
    .i_mem_full          (i_mem_full),
    .i_ber_samp_I        (i_ber_samp_I),
    .i_ber_samp_Q        (i_ber_samp_Q),
    .i_ber_error_I       (i_ber_error_I),
    .i_ber_error_Q       (i_ber_error_Q),
    .o_gpi               (o_gpi),
    .o_rst               (o_rst),
    .o_enbTx             (o_enbTx),
    .o_enbRx             (o_enbRx),
    .o_phase_sel         (o_phase_sel),
    .o_run_log           (o_run_log),
    .o_read_log          (o_read_log),
    .o_addr_log_to_mem   (o_addr_log_to_mem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply the command rules to the inputs seen at this clock edge.
  task automatic model_step();
    logic [3:0]  op;
    logic [22:0] d;
    bit          fire;
    if (i_rst) begin
      m_gpi = 0; m_rst = 0; m_tx = 0; m_rx = 0; m_ph = 0; m_run = 0; m_read = 0;
      m_addr = 0; m_snap = 0; m_src = "STAT"; m_prev = 0;
      return;
    end
    fire   = i_gpo[23] && !m_prev && (i_gpo[31:28] == 4'd0);
    m_prev = i_gpo[23];
    op     = i_gpo[27:24];
    d      = i_gpo[22:0];
    m_run  = fire && op == 4;
    m_read = fire && op == 5;
    if (fire) begin
      if (op == 0) m_rst = d[0];
      if (op == 1) m_tx = d[0];
      if (op == 2) m_rx = d[0];
      if (op == 3) m_ph = d[1:0];
      if (op == 6) begin m_addr = d[NB_ADDR_MEM-1:0]; m_src = "MEM"; end
      if (op >= 7 && op <= 10) begin
        m_snap = (op == 7) ? i_ber_samp_I : (op == 8) ? i_ber_samp_Q :
                 (op == 9) ? i_ber_error_I : i_ber_error_Q;
        m_gpi  = m_snap[31:0];
        m_src  = "BER";
      end
      if (op == 11) begin m_gpi = m_snap[63:32]; m_src = "BER"; end
      if (op == 12) m_src = "STAT";
`ifdef REGFILE_ECHO_EN
      if (op == 13) begin m_gpi = {9'b0, d}; m_src = "BER"; end
`endif
    end
    if (m_src == "MEM")  m_gpi = i_data_log_from_mem;
    if (m_src == "STAT") m_gpi = {31'b0, i_mem_full};
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("gpi",      o_gpi,             m_gpi);
    check("rst",      o_rst,             m_rst);
    check("enbTx",    o_enbTx,           m_tx);
    check("enbRx",    o_enbRx,           m_rx);
    check("phase",    o_phase_sel,       m_ph);
    check("run_log",  o_run_log,         m_run);
    check("read_log", o_read_log,        m_read);
    check("addr",     o_addr_log_to_mem, m_addr);
  endtask

  task automatic send(input logic [3:0] op, input logic [22:0] d, input int unsigned hold);
    i_gpo = {4'b0, op, 1'b1, d};
    repeat (hold) step();
    i_gpo[23] = 1'b0;
    step();
  endtask

  initial begin
    int unsigned pulses;
    logic [31:0] snap_gpi;
    i_rst = 1'b1; i_gpo = '0; i_data_log_from_mem = '0; i_mem_full = 1'b0;
    i_ber_samp_I = '0; i_ber_samp_Q = '0; i_ber_error_I = '0; i_ber_error_Q = '0;
    repeat (3) step();
    i_rst = 1'b0;
    repeat (2) step();
    check("idle_gpi_empty", o_gpi, 0);
    i_mem_full = 1'b1;
    step();
    check("idle_gpi_full", o_gpi, 1);

    i_gpo = 32'h0180_0001;
    step();
    check("entx_set", o_enbTx, 1);
    repeat (4) step();
    check("entx_hold", o_enbTx, 1);
    i_gpo = '0;
    step();
    i_gpo = 32'h0180_0000;
    step();
    check("entx_clear", o_enbTx, 0);
    i_gpo = '0;
    step();

    send(4'd3, 23'd2, 1);
    check("phase_2", o_phase_sel, 2);
    i_gpo = {4'b0, 4'd4, 1'b1, 23'd0};
    pulses = 0;
    repeat (10) begin step(); pulses += o_run_log; end
    check("run_pulse_cnt", pulses, 1);
    i_gpo = '0;
    step();

    send(4'd6, 23'h1234, 1);
    check("addr_1234", o_addr_log_to_mem, 15'h1234);
    i_data_log_from_mem = 32'hDEAD_BEEF;
    step();
    check("mem_readback", o_gpi, 32'hDEAD_BEEF);

    i_ber_error_Q = 64'h1111_2222_3333_4444;
    send(4'd10, 23'd0, 1);
    check("ber_eq_lo", o_gpi, 32'h3333_4444);
    i_ber_error_Q = 64'hAAAA_BBBB_CCCC_DDDD;
    send(4'd11, 23'd0, 1);
    check("ber_hi_snap", o_gpi, 32'h1111_2222);

    snap_gpi = o_gpi;
    send(4'd14, 23'h7F_FFFF, 1);
    check("op14_gpi", o_gpi, snap_gpi);
    send(4'd13, 23'h7A_BCDE, 1);
`ifdef REGFILE_ECHO_EN
    check("echo_gpi", o_gpi, 32'h007A_BCDE);
`else
    check("op13_gpi", o_gpi, snap_gpi);
`endif

    // strobe already high while reset is asserted fires once on release
    i_rst = 1'b1;
    i_gpo = 32'h0280_0001;
    repeat (2) step();
    i_rst = 1'b0;
    step();
    check("rst_release_cmd", o_enbRx, 1);
    i_gpo = '0;
    step();

    for (int unsigned cyc = 0; cyc < 2000; cyc++) begin
      i_rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) == 0) begin
        i_gpo[31:28] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        i_gpo[27:24] = 4'($urandom_range(0, 15));
        i_gpo[22:0]  = 23'($urandom);
      end
      if ($urandom_range(0, 1) == 0) i_gpo[23] = ~i_gpo[23];
      i_data_log_from_mem = $urandom;
      i_mem_full          = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        i_ber_samp_I  = {$urandom, $urandom};
        i_ber_samp_Q  = {$urandom, $urandom};
        i_ber_error_I = {$urandom, $urandom};
        i_ber_error_Q = {$urandom, $urandom};
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Control/status bridge between the soft microprocessor GPIO pair (i_gpo/o_gpi) and the datapath.
- Decodes one 32-bit command word per strobe edge. Drives the system controls: reset, Tx/Rx enables, filter phase select, and log-memory run/read/address.
- Returns log-memory data, the memory-full flag and 64-bit BER counters on o_gpi, 32 bits at a time.

Parameters:
- NB_ADDR_MEM, 15, width of the log-memory read address.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_gpo  in  32  command word: [31:24] opcode (only [27:24] decoded, [31:28] must be 0), [23] strobe, [22:0] data.
- i_data_log_from_mem  in  32  read data from the log memory.
- i_mem_full  in  1  log memory has finished capturing.
- i_ber_samp_I  in  64  BER sample counter, I branch.
- i_ber_samp_Q  in  64  BER sample counter, Q branch.
- i_ber_error_I  in  64  BER error counter, I branch.
- i_ber_error_Q  in  64  BER error counter, Q branch.
- o_gpi  out  32  readback word to the processor.
- o_rst  out  1  datapath reset level.
- o_enbTx  out  1  transmitter enable.
- o_enbRx  out  1  receiver enable.
- o_phase_sel  out  2  filter phase select.
- o_run_log  out  1  one-cycle pulse: start logging.
- o_read_log  out  1  one-cycle pulse: enter memory read mode.
- o_addr_log_to_mem  out  NB_ADDR_MEM  log-memory read address.

Behaviour:
- Strobe detection: register i_gpo[23] into strobe_d (reset 0).
  - A command executes in the cycle where i_gpo[23]=1 and strobe_d=0.
  - A held strobe executes only once.
  - A strobe already high when reset releases executes once.
- All outputs are registered. Effect is visible the cycle after the edge cycle, i.e. 1-clock latency.
- Opcodes:
  - 0 RESET: o_rst<=data[0].
  - 1 EN_TX: o_enbTx<=data[0].
  - 2 EN_RX: o_enbRx<=data[0].
  - 3 PH_SEL: o_phase_sel<=data[1:0].
  - 4 RUN_MEM: o_run_log=1 for exactly one cycle.
  - 5 READ_MEM: o_read_log=1 for exactly one cycle.
  - 6 ADDR_MEM: o_addr_log_to_mem<=data[NB_ADDR_MEM-1:0]; readback source := MEM.
  - 7 BER_SI / 8 BER_SQ / 9 BER_EI / 10 BER_EQ: snapshot the selected full 64-bit counter into ber_snap in the edge cycle; o_gpi<=snapshot[31:0].
  - 11 BER_HI: o_gpi<=ber_snap[63:32]. This is the same snapshot, so low and high halves are coherent.
  - 12 MEM_STAT: readback source := STAT, o_gpi={31'b0,i_mem_full}.
  - 13 (see Optional Feature), 14, 15 and any opcode with [31:28]≠0: no effect on any output.
- Readback source register (reset STAT):
  - MEM: o_gpi<=i_data_log_from_mem every cycle, so data tracks address after the memory's read latency.
  - STAT: o_gpi<={31'b0,i_mem_full} every cycle.
  - BER: o_gpi holds the last BER word. Opcodes 7–11 set the source to BER.
- Reset values: o_gpi=0, o_rst=0, o_enbTx=0, o_enbRx=0, o_phase_sel=0, o_run_log=0, o_read_log=0, o_addr_log_to_mem=0, ber_snap=0, strobe_d=0.
- Reset asserted mid-operation overrides any command in the same cycle.
- Unused data bits are ignored.
- Non-pulse controls hold their value until rewritten.

Optional Feature:
- Macro REGFILE_ECHO_EN.
- Defined: opcode 13 ECHO sets readback source BER-style hold with o_gpi<={9'b0,data[22:0]}, for link testing.
- Undefined: opcode 13 is a no-op like 14/15.

Decomposition:
- Package regfile_pkg holds:
  - opcode localparams: RESET=0, EN_TX=1, EN_RX=2, PH_SEL=3, RUN_MEM=4, READ_MEM=5, ADDR_MEM=6, BER_SI=7, BER_SQ=8, BER_EI=9, BER_EQ=10, BER_HI=11, MEM_STAT=12, ECHO=13;
  - field positions (opcode [27:24], strobe bit 23, data [22:0]);
  - readback-source encoding (STAT, MEM, BER).
- Sub-module gpo_strobe_detect: rising-edge detector on bit 23, producing a one-cycle cmd_valid.

Test Plan:
- Reset then idle: all outputs 0; o_gpi=0 with i_mem_full=0, and o_gpi=1 after i_mem_full=1.
- i_gpo=0x0180_0001 (EN_TX, strobe, data=1) held 5 cycles: o_enbTx=1 one cycle after the edge, stays 1; strobe low then 0x0180_0000 clears it.
- PH_SEL data=2 gives o_phase_sel=2. RUN_MEM strobe held 10 cycles: o_run_log high exactly 1 cycle.
- ADDR_MEM data=0x1234: o_addr_log_to_mem=0x1234; driving i_data_log_from_mem=0xDEADBEEF gives o_gpi=0xDEADBEEF next cycle.
- i_ber_error_Q=0x1111_2222_3333_4444: BER_EQ gives o_gpi=0x33334444. Change the input, then BER_HI gives o_gpi=0x11112222, the snapshot value.
- Opcode 14 and, without REGFILE_ECHO_EN, opcode 13 leave all outputs unchanged. With the macro, ECHO data=0x7ABCDE gives o_gpi=0x007ABCDE.
